simple_bus: RTL and testbench
=============================

SIMPLE_BUS -- requirements
Module: simple_bus

Interface
REQ-001 SHALL have parameter NrDevices, default 1: number of device (slave) ports, minimum 1.
REQ-002 SHALL have parameter NrHosts, default 1: number of host (master) ports, minimum 1.
REQ-003 SHALL have parameter DataWidth, default 32: data bus width in bits.
REQ-004 SHALL have parameter AddressWidth, default 32: address width in bits.
REQ-005 SHALL have one clock and an asynchronous, active-high reset (fixed): clk_i  input  1  clock, rising edge; rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have host ports, each an unpacked array [NrHosts]:
- host_req_i  input  1  request
- host_gnt_o  output  1  grant
- host_addr_i  input  AddressWidth  address
- host_we_i  input  1  write enable
- host_be_i  input  DataWidth/8  byte enables
- host_wdata_i  input  DataWidth  write data
- host_rvalid_o  output  1  response valid
- host_rdata_o  output  DataWidth  read data
- host_err_o  output  1  response error
REQ-007 SHALL have device ports, each an unpacked array [NrDevices]:
- device_req_o  output  1  request
- device_addr_o  output  AddressWidth  address
- device_we_o  output  1  write enable
- device_be_o  output  DataWidth/8  byte enables
- device_wdata_o  output  DataWidth  write data
- device_rvalid_i  input  1  response valid
- device_rdata_i  input  DataWidth  read data
- device_err_i  input  1  response error
REQ-008 SHALL have address map inputs, each an unpacked array [NrDevices]:
- cfg_device_addr_base  input  AddressWidth  region base
- cfg_device_addr_mask  input  AddressWidth  region mask

Function
REQ-009 SHALL arbitrate combinationally with fixed priority: lowest-index host with host_req_i=1 wins.
REQ-010 SHALL decode the winning address: device d matches when (addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]; among several matches the lowest index wins.
REQ-011 SHALL assert host_gnt_o only for the winning host, in the same cycle as its request; all other grants 0; no host requesting gives all grants 0.
REQ-012 SHALL assert device_req_o only for the matched device, in the same cycle as the winning request.
REQ-013 SHALL broadcast the winner's addr, we, be and wdata on every device port, unmodified.
REQ-014 SHALL register the winner host index, matched device index and an unmapped flag on each granted cycle, steering exactly one response per grant.
REQ-015 SHALL route responses: host_rvalid_o, host_rdata_o and host_err_o of the registered host equal device_rvalid_i, device_rdata_i and device_err_i of the registered device; non-selected hosts output rvalid=0, rdata=0, err=0.
REQ-016 SHALL grant an unmapped request without asserting any device_req_o, then drive rvalid=1, err=1, rdata=0 to that host exactly one cycle later.
REQ-017 SHALL require single-cycle device response latency; back-to-back grants on consecutive cycles SHALL be supported.
REQ-018 SHALL treat the response path as purely combinational from device_*_i given the registered selection, adding no latency.

Reset
REQ-019 SHALL clear registered host index, device index and unmapped flag to 0 while rst_i=1, asynchronously.
REQ-020 SHALL drive host_rvalid_o=0 and host_err_o=0 during reset and in the first cycle after reset, regardless of device inputs.
REQ-021 SHALL silently drop a response pending when reset asserts mid-transaction.

Structure
REQ-022 SHALL be self-contained; a shared package is not required, and index widths SHALL be computed locally as $clog2 of the counts, minimum 1.
REQ-023 SHALL be a single module; a combinational sub-module bus_addr_decode (address to index plus hit) is permitted.

Verification
REQ-024 SHALL pass the following directed scenarios, using map Ram base 0x100000 / mask ~0xFFFFF, SimCtrl base 0x20000 / mask ~0x3FF, Timer base 0x30000 / mask ~0x3FF:
- Host0 read 0x100004, Ram returns rvalid with 0xDEADBEEF next cycle -> gnt same cycle, device_req_o[0]=1, host_rdata_o[0]=0xDEADBEEF, err=0.
- Host0 write 0x20000, data 0x41, be 0xF -> device_req_o[1]=1, device_wdata_o=0x41, device_we_o=1, others req=0.
- Host0 read 0x40000 (unmapped) -> gnt=1, no device_req_o, next cycle rvalid=1, err=1, rdata=0.
- Two hosts (NrHosts=2) request together -> host0 granted, host1 gnt=0; host1 granted the following cycle after host0 drops its request.
- Timer returns device_err_i=1 -> host_err_o[0]=1 in the response cycle.
- rst_i asserted during a pending response -> no rvalid is produced.

Source files
------------

// File: rtl/bus_addr_decode.sv
// Address decoder for the bus. Maps an address to the lowest-indexed device
// region that contains it, and flags whether any region contains it.
module bus_addr_decode #(
  parameter int NrDevices    = 1,
  parameter int AddressWidth = 32,
  parameter int IdxW         = 1
) (
  input  logic [AddressWidth-1:0] addr,
  input  logic [AddressWidth-1:0] base [NrDevices],
  input  logic [AddressWidth-1:0] mask [NrDevices],
  output logic [IdxW-1:0]         idx,
  output logic                    hit
);

  // Scan from the top down so that a lower-index match overwrites a higher one.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((addr & mask[d]) == base[d]) begin
        idx = IdxW'(d);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simple_bus.sv
// Single-transaction-per-cycle bus fabric: fixed-priority host arbitration,
// address decode to devices, and registered steering of the one-cycle response.
module simple_bus #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      host_req_i     [NrHosts],
  output logic                      host_gnt_o     [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i    [NrHosts],
  input  logic                      host_we_i      [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i      [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i   [NrHosts],
  output logic                      host_rvalid_o  [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o   [NrHosts],
  output logic                      host_err_o     [NrHosts],

  output logic                      device_req_o   [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
  output logic                      device_we_o    [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic                      device_rvalid_i[NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic                      device_err_i   [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int BeW      = DataWidth / 8;

  logic [HostIdxW-1:0]     win_idx;
  logic                    win_any;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeW-1:0]          win_be;
  logic [DataWidth-1:0]    win_wdata;

  logic [DevIdxW-1:0]      dec_idx;
  logic                    dec_hit;

  logic [HostIdxW-1:0]     host_q;
  logic [DevIdxW-1:0]      dev_q;
  logic                    unmapped_q;
  logic                    pend_q;

  logic                    rsp_vld;
  logic [DataWidth-1:0]    rsp_data;
  logic                    rsp_err;

  // Fixed priority: scan downwards so the lowest requesting index wins.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        win_idx = HostIdxW'(h);
        win_any = 1'b1;
      end
    end
  end

  always_comb begin
    win_addr  = host_addr_i[0];
    win_we    = host_we_i[0];
    win_be    = host_be_i[0];
    win_wdata = host_wdata_i[0];
    for (int h = 0; h < NrHosts; h++) begin
      if (win_idx == HostIdxW'(h)) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  bus_addr_decode #(
    .NrDevices   (NrDevices),
    .AddressWidth(AddressWidth),
    .IdxW        (DevIdxW)
  ) u_dec (
    .addr(win_addr),
    .base(cfg_device_addr_base),
    .mask(cfg_device_addr_mask),
    .idx (dec_idx),
    .hit (dec_hit)
  );

  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = win_any && (win_idx == HostIdxW'(h));
    end
  end

  // Request payload is broadcast; only the matched device sees req.
  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = win_any && dec_hit && (dec_idx == DevIdxW'(d));
      device_addr_o[d]  = win_addr;
      device_we_o[d]    = win_we;
      device_be_o[d]    = win_be;
      device_wdata_o[d] = win_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_q     <= '0;
      dev_q      <= '0;
      unmapped_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      pend_q <= win_any;
      if (win_any) begin
        host_q     <= win_idx;
        dev_q      <= dec_idx;
        unmapped_q <= ~dec_hit;
      end
    end
  end

  // An unmapped grant is answered by the fabric itself with an error.
  always_comb begin
    rsp_vld  = 1'b0;
    rsp_data = '0;
    rsp_err  = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (dev_q == DevIdxW'(d)) begin
        rsp_vld  = device_rvalid_i[d];
        rsp_data = device_rdata_i[d];
        rsp_err  = device_err_i[d];
      end
    end
    if (unmapped_q) begin
      rsp_vld  = 1'b1;
      rsp_data = '0;
      rsp_err  = 1'b1;
    end
  end

  // pend_q gates the response so idle cycles and the cycle after reset stay quiet.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      if (pend_q && (host_q == HostIdxW'(h))) begin
        host_rvalid_o[h] = rsp_vld;
        host_rdata_o[h]  = rsp_data;
        host_err_o[h]    = rsp_err;
      end else begin
        host_rvalid_o[h] = 1'b0;
        host_rdata_o[h]  = '0;
        host_err_o[h]    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simple_bus.sv
// Directed scoreboard bench for simple_bus with two hosts and three devices
// (Ram, SimCtrl, Timer); the bench plays the devices.
module tb_simple_bus;
  localparam int NH = 2;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          host_req_i     [NH];
  logic          host_gnt_o     [NH];
  logic [AW-1:0] host_addr_i    [NH];
  logic          host_we_i      [NH];
  logic [DW/8-1:0] host_be_i    [NH];
  logic [DW-1:0] host_wdata_i   [NH];
  logic          host_rvalid_o  [NH];
  logic [DW-1:0] host_rdata_o   [NH];
  logic          host_err_o     [NH];
  logic          device_req_o   [ND];
  logic [AW-1:0] device_addr_o  [ND];
  logic          device_we_o    [ND];
  logic [DW/8-1:0] device_be_o  [ND];
  logic [DW-1:0] device_wdata_o [ND];
  logic          device_rvalid_i[ND];
  logic [DW-1:0] device_rdata_i [ND];
  logic          device_err_i   [ND];
  logic [AW-1:0] cfg_base       [ND];
  logic [AW-1:0] cfg_mask       [ND];

  simple_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  typedef struct {
    int          host;
    bit          hit;
    int          dev;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  bit          cur_vld = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] nxt_rdata;
  logic        nxt_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_dec(input logic [31:0] a, output bit hit, output int dev);
    hit = 0;
    dev = 0;
    for (int d = 0; d < ND; d++) begin
      if (!hit && ((a & cfg_mask[d]) == cfg_base[d])) begin
        hit = 1;
        dev = d;
      end
    end
  endfunction

  task automatic idle_hosts();
    for (int h = 0; h < NH; h++) begin
      host_req_i[h] = 0; host_addr_i[h] = '0; host_we_i[h] = 0;
      host_be_i[h] = '0; host_wdata_i[h] = '0;
    end
  endtask

  // Non-responding devices carry random data so leakage shows up.
  task automatic clr_dev();
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 0;
      device_rdata_i[d]  = $urandom;
      device_err_i[d]    = 0;
    end
  endtask

  task automatic drive(input int h, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] be);
    host_req_i[h] = 1; host_addr_i[h] = a; host_we_i[h] = we;
    host_wdata_i[h] = wd; host_be_i[h] = be;
  endtask

  task automatic step_begin();
    @(posedge clk);
    #1;
    clr_dev();
    cur_vld = 0;
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      cur_vld = 1;
      if (cur.hit) begin
        device_rvalid_i[cur.dev] = 1;
        device_rdata_i[cur.dev]  = cur.rdata;
        device_err_i[cur.dev]    = cur.err;
      end
    end
  endtask

  task automatic check_cycle(input int exp_win);
    exp_t e;
    bit   hit;
    int   dev;
    #4;
    for (int h = 0; h < NH; h++) begin
      if (cur_vld && h == cur.host) begin
        chk($sformatf("rvalid%0d", h), host_rvalid_o[h], 1);
        chk($sformatf("rdata%0d", h), host_rdata_o[h], cur.hit ? cur.rdata : 32'h0);
        chk($sformatf("err%0d", h), host_err_o[h], cur.hit ? cur.err : 1'b1);
      end else begin
        chk($sformatf("rvalid_off%0d", h), host_rvalid_o[h], 0);
        chk($sformatf("rdata_off%0d", h), host_rdata_o[h], 0);
      end
      chk($sformatf("gnt%0d", h), host_gnt_o[h], h == exp_win);
    end
    if (exp_win >= 0) begin
      model_dec(host_addr_i[exp_win], hit, dev);
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("dreq%0d", d), device_req_o[d], hit && dev == d);
        chk($sformatf("daddr%0d", d), device_addr_o[d], host_addr_i[exp_win]);
        chk($sformatf("dwe%0d", d), device_we_o[d], host_we_i[exp_win]);
        chk($sformatf("dbe%0d", d), device_be_o[d], host_be_i[exp_win]);
        chk($sformatf("dwdata%0d", d), device_wdata_o[d], host_wdata_i[exp_win]);
      end
      e.host = exp_win; e.hit = hit; e.dev = dev; e.rdata = nxt_rdata; e.err = nxt_err;
      sbq.push_back(e);
    end else begin
      for (int d = 0; d < ND; d++) chk($sformatf("dreq_idle%0d", d), device_req_o[d], 0);
    end
  endtask

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    idle_hosts();
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 1; device_rdata_i[d] = 32'hA5A5_0000 + d; device_err_i[d] = 1;
    end
    nxt_rdata = '0; nxt_err = 0;

    // Reset: responses must stay quiet even with devices shouting.
    #2;
    for (int h = 0; h < NH; h++) begin
      chk("rst_rvalid", host_rvalid_o[h], 0);
      chk("rst_err", host_err_o[h], 0);
      chk("rst_gnt", host_gnt_o[h], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #3;
    for (int h = 0; h < NH; h++) begin
      chk("post_rst_rvalid", host_rvalid_o[h], 0);
      chk("post_rst_err", host_err_o[h], 0);
    end

    // Ram read
    step_begin(); drive(0, 32'h0010_0004, 0, 32'h0, 4'hF);
    nxt_rdata = 32'hDEAD_BEEF; nxt_err = 0; check_cycle(0);
    // SimCtrl write
    step_begin(); idle_hosts(); drive(0, 32'h0002_0000, 1, 32'h41, 4'hF);
    nxt_rdata = 32'h0; nxt_err = 0; check_cycle(0);
    // Unmapped
    step_begin(); idle_hosts(); drive(0, 32'h0004_0000, 0, 32'h0, 4'hF);
    nxt_rdata = 32'h1234_5678; nxt_err = 0; check_cycle(0);
    step_begin(); idle_hosts(); check_cycle(-1);

    // Both hosts together, then host1 back-to-back
    step_begin(); drive(0, 32'h0010_0008, 0, 32'h0, 4'hF); drive(1, 32'h0003_0004, 0, 32'h0, 4'h3);
    nxt_rdata = 32'hCAFE_0001; nxt_err = 0; check_cycle(0);
    step_begin(); host_req_i[0] = 0;
    nxt_rdata = 32'hCAFE_0002; nxt_err = 0; check_cycle(1);
    // Timer error to host0, then host1 Ram write, then host1 unmapped
    step_begin(); idle_hosts(); drive(0, 32'h0003_0008, 0, 32'h0, 4'hF);
    nxt_rdata = 32'h0BAD_0BAD; nxt_err = 1; check_cycle(0);
    step_begin(); idle_hosts(); drive(1, 32'h001F_FFFC, 1, 32'h7777_8888, 4'hC);
    nxt_rdata = 32'h0; nxt_err = 0; check_cycle(1);
    step_begin(); idle_hosts(); drive(1, 32'h0002_0400, 0, 32'h0, 4'hF);
    nxt_rdata = 32'h0; nxt_err = 0; check_cycle(1);
    step_begin(); idle_hosts(); check_cycle(-1);
    step_begin(); check_cycle(-1);

    // Reset while a response is pending
    step_begin(); drive(0, 32'h0010_0000, 0, 32'h0, 4'hF);
    nxt_rdata = 32'h5555_AAAA; nxt_err = 0; check_cycle(0);
    @(posedge clk);
    #1 rst = 1;
    idle_hosts(); sbq.delete(); cur_vld = 0;
    device_rvalid_i[0] = 1; device_rdata_i[0] = 32'h5555_AAAA; device_err_i[0] = 1;
    #3;
    chk("rst_mid_rvalid", host_rvalid_o[0], 0);
    chk("rst_mid_err", host_err_o[0], 0);
    @(posedge clk);
    #1 rst = 0;
    #3;
    chk("rst_rel_rvalid", host_rvalid_o[0], 0);
    chk("rst_rel_err", host_err_o[0], 0);

    // Function resumes after reset
    step_begin(); drive(1, 32'h0010_0010, 0, 32'h0, 4'hF);
    nxt_rdata = 32'h0F0F_F0F0; nxt_err = 0; check_cycle(1);
    step_begin(); idle_hosts(); check_cycle(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
